gbdt_round_ctrl: RTL

GBDT_ROUND_CTRL -- requirements
Module: gbdt_round_ctrl

---
 rtl/gbdt_round_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/gbdt_round_ctrl.sv
// gbdt_round_ctrl
// ----------------------------------------------------------------------------
// Round controller for a gradient-boosted decision tree inference engine.
// A host start request launches the tree walker from node address 0. Leaf
// values are accumulated into a saturating signed score while the walker runs.
// The score is then presented to the host with a valid/ready handshake.
//
// Optional feature (macro GBDT_WATCHDOG_EN): a WALK-cycle watchdog. It aborts
// a round after WDOG_CYCLES walk cycles without a finishing leaf and raises
// err_timeout. Without the macro, err_timeout is tied low and no counter exists.
//
// Ports:
//   gbdt_clk, gbdt_rst_n  clock (rising edge), async active-low reset
//   start_req / start_ack host start request / one-cycle acceptance pulse
//   walk_enable/walk_done tree-walker control
//   is_leaf, leaf_val,    per-cycle node data from tree RAM (valid in WALK)
//   finish_condition
//   score, score_valid,   accumulated result and handshake
//   score_ready
//   tree_cnt              leaves accumulated this round (saturating)
//   score_sat             sticky clamp flag for this round
//   busy                  controller not idle
//   err_timeout           watchdog fired this round
// ----------------------------------------------------------------------------
module gbdt_round_ctrl #(
  parameter int unsigned SCORE_W     = 20,
  parameter int unsigned TREE_CNT_W  = 10,
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input  logic                  gbdt_clk,
  input  logic                  gbdt_rst_n,
  input  logic                  start_req,
  output logic                  start_ack,
  output logic                  walk_enable,
  output logic                  walk_done,
  input  logic                  is_leaf,
  input  logic [15:0]           leaf_val,
  input  logic                  finish_condition,
  output logic [SCORE_W-1:0]    score,
  output logic                  score_valid,
  input  logic                  score_ready,
  output logic [TREE_CNT_W-1:0] tree_cnt,
  output logic                  score_sat,
  output logic                  busy,
  output logic                  err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WALK,
    S_OUT
  } state_e;

  localparam logic [SCORE_W-1:0] ScoreMax = {1'b0, {(SCORE_W-1){1'b1}}};
  localparam logic [SCORE_W-1:0] ScoreMin = {1'b1, {(SCORE_W-1){1'b0}}};

  state_e                  state_q, state_d;
  logic [SCORE_W-1:0]      score_q, score_d;
  logic [TREE_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    sat_q, sat_d;
  logic [SCORE_W:0]        sum;
  logic                    pos_ovf, neg_ovf;
  logic                    wdog_expire;

  // One guard bit is enough: a single 16-bit leaf cannot overflow by more
  // than one bit of a score at least 16 bits wide.
  assign sum     = {score_q[SCORE_W-1], score_q}
                 + {{(SCORE_W+1-16){leaf_val[15]}}, leaf_val};
  assign pos_ovf = (sum[SCORE_W:SCORE_W-1] == 2'b01);
  assign neg_ovf = (sum[SCORE_W:SCORE_W-1] == 2'b10);

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    start_ack = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_req && gbdt_rst_n) begin
          start_ack = 1'b1;
          state_d   = S_LAUNCH;
          score_d   = '0;
          cnt_d     = '0;
          sat_d     = 1'b0;
        end
      end
      S_LAUNCH: state_d = S_WALK;
      S_WALK: begin
        if (is_leaf) begin
          if (pos_ovf) begin
            score_d = ScoreMax;
            sat_d   = 1'b1;
          end else if (neg_ovf) begin
            score_d = ScoreMin;
            sat_d   = 1'b1;
          end else begin
            score_d = sum[SCORE_W-1:0];
          end
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (finish_condition) state_d = S_OUT;
        end
        if (wdog_expire) state_d = S_OUT;
      end
      S_OUT: begin
        // A simultaneous start_req is deliberately not accepted here.
        if (score_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
    if (!gbdt_rst_n) begin
      state_q <= S_IDLE;
      score_q <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

`ifdef GBDT_WATCHDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);

  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             err_q, err_d;

  // wdog_q holds the number of WALK cycles already completed, so the
  // WDOG_CYCLES-th walk cycle is the one that sees WDOG_CYCLES-1.
  assign wdog_expire = (state_q == S_WALK)
                    && (wdog_q == WdogW'(WDOG_CYCLES - 1))
                    && !(is_leaf && finish_condition);

  always_comb begin
    wdog_d = wdog_q;
    err_d  = err_q;
    if (state_q == S_LAUNCH) wdog_d = '0;
    else if (state_q == S_WALK) wdog_d = wdog_q + 1'b1;
    if (start_ack) err_d = 1'b0;
    else if (wdog_expire) err_d = 1'b1;
  end

  always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
    if (!gbdt_rst_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^WDOG_CYCLES;
  assign wdog_expire     = 1'b0;
  assign err_timeout     = 1'b0;
`endif

  assign walk_enable = (state_q == S_LAUNCH) || (state_q == S_WALK);
  assign walk_done   = (state_q != S_WALK);
  assign busy        = (state_q != S_IDLE);
  assign score_valid = (state_q == S_OUT);
  assign score       = score_q;
  assign tree_cnt    = cnt_q;
  assign score_sat   = sat_q;

endmodule
